// File: rtl/ma_sample_feeder.sv
// ma_sample_feeder: FIFO-buffered sample source that replays samples as paced din/data_refresh strobes for the moving-average filter.
module ma_sample_feeder #(
  parameter int DEPTH = 8,
  parameter int DIV_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [15:0]              s_data,
  input  logic [DIV_W-1:0]         interval,
  input  logic                     clr_underrun,
  output logic [15:0]              din,
  output logic                     data_refresh,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              issued_cnt,
  output logic                     underrun
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, RUN, STARVED} state_t;
  state_t           state_q;
  logic [DIV_W-1:0] cnt_q;
  logic [15:0]      mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      level_q;
  logic [15:0]      din_q, issued_q;
  logic             refresh_q, underrun_q;
  logic             empty, push, due, issue, starve;
  always_comb begin
    empty  = level_q == '0;
    push   = s_valid && s_ready;
    due    = state_q != RUN || cnt_q == '0;
    issue  = enable && due && !empty;
    starve = enable && state_q == RUN && cnt_q == '0 && empty;
  end
  assign s_ready      = level_q != (AW+1)'(DEPTH);
  assign din          = din_q;
  assign data_refresh = refresh_q;
  assign level        = level_q;
  assign issued_cnt   = issued_q;
  assign underrun     = underrun_q;
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= s_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      level_q    <= '0;
      din_q      <= '0;
      issued_q   <= '0;
      refresh_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (issue) begin
        rd_q     <= rd_q + 1'b1;
        din_q    <= mem_q[rd_q];
        issued_q <= issued_q + 16'd1;
      end
      level_q    <= level_q + (AW+1)'(push) - (AW+1)'(issue);
      refresh_q  <= issue;
      underrun_q <= starve | (underrun_q & ~clr_underrun);
      // Paused pacer keeps both state and count so the interval resumes where it stopped.
      if (issue) begin
        state_q <= RUN;
        cnt_q   <= interval;
      end else if (starve) begin
        state_q <= STARVED;
      end else if (enable && state_q == RUN) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ma_sample_feeder.sv
// tb_ma_sample_feeder: queue-based reference model feeding a scoreboard that checks strobes, samples and status.
module tb_ma_sample_feeder;
  localparam int DEPTH = 8;
  logic        clk = 0, rst = 1, enable = 0, s_valid = 0, clr_underrun = 0;
  logic [15:0] s_data = 0;
  logic [7:0]  interval = 0;
  logic        s_ready, data_refresh, underrun;
  logic [15:0] din, issued_cnt;
  logic [3:0]  level;

  ma_sample_feeder #(.DEPTH(DEPTH), .DIV_W(8)) dut (
    .clk(clk), .rst(rst), .enable(enable), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .interval(interval), .clr_underrun(clr_underrun), .din(din),
    .data_refresh(data_refresh), .level(level), .issued_cnt(issued_cnt), .underrun(underrun)
  );

  always #5 clk = ~clk;

  typedef struct {int cyc; logic [15:0] d; logic [15:0] n;} exp_t;
  exp_t        exp_q[$];
  logic [15:0] mq[$];
  int          cyc = 0, remain = 0, n_cmp = 0, n_fail = 0;
  bit          primed = 1, armed = 0, ur_m = 0;
  logic [15:0] din_m = 0, issued_m = 0;

  task automatic chk(string nm, int act, int req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, req);
    end
  endtask

  // Reference model: a sample queue plus "cycles until next due"; waiting for data is one merged state.
  always @(posedge clk) begin
    bit set, iss, psh;
    cyc++;
    if (rst) begin
      mq.delete(); exp_q.delete();
      primed = 1; remain = 0; ur_m = 0; issued_m = 0; din_m = 0; armed = 1;
    end else begin
      set = 0; iss = 0;
      psh = s_valid && mq.size() < DEPTH;
      if (enable) begin
        if (primed || remain == 0) begin
          if (mq.size() > 0) iss = 1;
          else if (!primed) begin set = 1; primed = 1; end
        end else remain--;
      end
      if (iss) begin
        din_m = mq.pop_front();
        issued_m++;
        remain = interval;
        primed = 0;
        exp_q.push_back('{cyc, din_m, issued_m});
      end
      ur_m = set ? 1'b1 : (clr_underrun ? 1'b0 : ur_m);
      if (psh) mq.push_back(s_data);
    end
  end

  always @(negedge clk) if (armed) begin
    bit exp_ref;
    exp_ref = exp_q.size() > 0 && exp_q[0].cyc == cyc;
    chk("data_refresh", data_refresh, exp_ref);
    if (exp_ref) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("strobe_din", din, e.d);
      chk("strobe_issued_cnt", issued_cnt, e.n);
    end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      void'(exp_q.pop_front());
    end
    chk("level", level, mq.size());
    chk("s_ready", s_ready, mq.size() < DEPTH);
    chk("underrun", underrun, ur_m);
    chk("din_hold", din, din_m);
    chk("issued_cnt", issued_cnt, issued_m);
  end

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(logic [15:0] v);
    s_valid = 1; s_data = v;
    step(1);
    s_valid = 0;
  endtask

  initial begin
    step(3);
    rst = 0; interval = 3; enable = 1;
    push(16'd3); push(16'd5); push(-16'sd7);
    step(25);
    clr_underrun = 1; step(1); clr_underrun = 0;
    enable = 0;
    for (int i = 0; i < DEPTH + 1; i++) push(16'($urandom));
    interval = 0; enable = 1;
    step(14);
    interval = 2; step(3);
    push(16'h7FFF); push(16'd1); push(16'd2);
    step(12);
    interval = 1; push(16'd10);
    clr_underrun = 1; step(6); clr_underrun = 0;
    step(2);
    clr_underrun = 1; step(1); clr_underrun = 0;
    interval = 5;
    for (int i = 0; i < 4; i++) push(16'($urandom));
    interval = 1; step(15);
    interval = 4;
    for (int i = 0; i < 3; i++) push(16'($urandom));
    step(2); enable = 0; step(5); enable = 1; step(15);
    enable = 0; interval = 3;
    for (int i = 0; i < 5; i++) push(16'($urandom));
    enable = 1; step(4);
    rst = 1; step(1); rst = 0;
    push(16'd11); step(5);
    for (int i = 0; i < 3000; i++) begin
      s_valid      = $urandom_range(0, 2) != 0;
      s_data       = 16'($urandom);
      enable       = $urandom_range(0, 7) != 0;
      clr_underrun = $urandom_range(0, 15) == 0;
      rst          = $urandom_range(0, 499) == 0;
      if ($urandom_range(0, 19) == 0) interval = 8'($urandom_range(0, 5));
      step(1);
    end
    s_valid = 0; rst = 0; enable = 1; clr_underrun = 0;
    step(40);
    chk("exp_queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/ma_sample_feeder.md
# ma_sample_feeder

Paced sample source for the moving-average filter input. It accepts signed 16-bit samples over a valid/ready handshake and buffers them in a small FIFO. It replays them as a registered `din` value plus a one-cycle `data_refresh` strobe at a programmable interval, which is the exact input protocol the filter consumes. It also reports FIFO level, issued-sample count and a sticky underrun flag for the control/status logic.

## Interface
- `DEPTH`, 8: FIFO depth in samples; power of two, at least 2.
- `DIV_W`, 8: width of the `interval` input.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  pacing enable; when low, the pacer freezes and pushes are still accepted.
- `s_valid`  in  1  upstream sample valid.
- `s_ready`  out  1  FIFO can accept; equals `!full`.
- `s_data`  in  16  signed upstream sample.
- `interval`  in  DIV_W  idle cycles between strobes; the strobe period is `interval+1` cycles.
- `clr_underrun`  in  1  clears the `underrun` flag.
- `din`  out  16  signed sample to the filter; registered; holds its value between strobes.
- `data_refresh`  out  1  one-cycle strobe; `din` is valid in the same cycle.
- `level`  out  log2(DEPTH)+1  FIFO occupancy, from 0 to DEPTH.
- `issued_cnt`  out  16  number of strobes issued; wraps modulo 2^16.
- `underrun`  out  1  sticky flag: the pacer was due to issue a sample but the FIFO was empty.

## Operation
- FIFO
  - Push occurs on `s_valid && s_ready`. Pop occurs only on an issue.
  - A pushed sample is poppable from the next cycle.
  - Push and pop may occur in the same cycle, in which case `level` is unchanged.
  - There is no push while full, because `s_ready` is low. Pop never happens while empty.
- Pacer state machine: states IDLE, RUN, STARVED. Down-counter `cnt` is DIV_W bits.
  - IDLE: if `enable` and the FIFO is not empty, issue, load `cnt <= interval`, and go to RUN. Underrun is never flagged in IDLE.
  - RUN, `cnt != 0`: decrement `cnt`.
  - RUN, `cnt == 0`, FIFO not empty: issue and reload `cnt`.
  - RUN, `cnt == 0`, FIFO empty: set `underrun` and go to STARVED.
  - STARVED: when the FIFO becomes not empty, issue immediately, reload `cnt`, and go to RUN.
  - `enable` low: state and `cnt` hold, there is no issue, and `data_refresh` is 0.
- An issue does all of the following:
  - `din <=` FIFO head.
  - `data_refresh <= 1` for exactly one cycle.
  - Pop the FIFO.
  - `issued_cnt <= issued_cnt + 1`.
- A change to `interval` takes effect at the next reload only; the running count is not disturbed.
- `interval = 0`: one strobe per cycle while data is available, back-to-back.
- `underrun`: set has priority over a simultaneous `clr_underrun`. Otherwise `clr_underrun` clears it.
- Arithmetic: samples pass through bit-exact with no scaling or saturation. `level` and `issued_cnt` are unsigned.

## Timing
- Reset values: `din=0`, `data_refresh=0`, `level=0`, `issued_cnt=0`, `underrun=0`, `s_ready=1`. State is IDLE and `cnt=0`.
- Reset asserted mid-operation discards the FIFO contents and any pending interval. A strobe that would fall in the reset cycle is suppressed.
- Latency from push into an empty FIFO (IDLE or STARVED, `enable` high) to `data_refresh` high is 2 cycles: the push edge, then the issue edge.
- Steady state with a non-empty FIFO: strobes exactly `interval+1` cycles apart.
- `s_ready` is combinational from `level`. It rises in the cycle after the pop that frees a slot.
- `level` and `issued_cnt` update on the same edge as the push or issue that changes them.

## Test plan
- Reset, then push 3, 5, -7 with `interval=3` and `enable=1`.
  - `data_refresh` pulses 4 cycles apart.
  - `din` carries 3, 5, -7 in order.
  - `issued_cnt` ends at 3.
  - `underrun` becomes 1 four cycles after the last strobe.
- Fill to DEPTH=8 with `enable=0`.
  - `s_ready=0` and `level=8`.
  - The extra `s_valid` sample is not accepted.
  - Raise `enable` with `interval=0`: 8 back-to-back strobes, then `level=0`.
- Starve: from STARVED, push 0x7FFF.
  - The strobe occurs 2 cycles after the push with `din=0x7FFF`.
  - Strobe spacing then returns to `interval+1`.
- Simultaneous events:
  - Push and pop in the same cycle keep `level` constant.
  - Underrun set together with `clr_underrun` leaves `underrun=1`.
  - `clr_underrun` alone clears it.
- Pause and interval change:
  - Drop `enable` mid-interval: `cnt` freezes and resumes at the same count.
  - Change `interval` from 5 to 1 mid-count: the current period stays at 6, the next periods are 2.
- Assert `rst` with 4 samples queued and a strobe due.
  - No strobe is issued.
  - All outputs return to their reset values.
  - A new push is issued 2 cycles later.
